// File: rtl/riscv_v_alu_group_sequencer_if.sv
// Handshake bundles around the vector ALU group sequencer: the instruction
// request from decode/issue and the per-register micro-op toward the ALU.

interface AluGroupReqIf #(
  parameter int REG_IDX_W   = 5,
  parameter int CTRL_W      = 32,
  parameter int LMUL_LOG2_W = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic [CTRL_W-1:0]      req_ctrl;
  logic [LMUL_LOG2_W-1:0] req_lmul_log2;
  logic [REG_IDX_W-1:0]   req_vs1;
  logic [REG_IDX_W-1:0]   req_vs2;
  logic [REG_IDX_W-1:0]   req_vd;
  logic                   req_is_reduct;
  logic                   req_is_mask_dst;

  modport master (
    output req_valid, req_ctrl, req_lmul_log2, req_vs1, req_vs2, req_vd,
           req_is_reduct, req_is_mask_dst,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_ctrl, req_lmul_log2, req_vs1, req_vs2, req_vd,
           req_is_reduct, req_is_mask_dst,
    output req_ready
  );
endinterface

interface AluGroupUopIf #(
  parameter int REG_IDX_W = 5,
  parameter int CTRL_W    = 32
);
  logic                 uop_valid;
  logic                 uop_ready;
  logic [CTRL_W-1:0]    uop_ctrl;
  logic [REG_IDX_W-1:0] uop_vs1;
  logic [REG_IDX_W-1:0] uop_vs2;
  logic [REG_IDX_W-1:0] uop_vd;
  logic [2:0]           uop_idx;
  logic                 uop_first;
  logic                 uop_last;
  logic                 uop_use_acc;

  modport master (
    output uop_valid, uop_ctrl, uop_vs1, uop_vs2, uop_vd, uop_idx,
           uop_first, uop_last, uop_use_acc,
    input  uop_ready
  );

  modport slave (
    input  uop_valid, uop_ctrl, uop_vs1, uop_vs2, uop_vd, uop_idx,
           uop_first, uop_last, uop_use_acc,
    output uop_ready
  );
endinterface

// File: rtl/riscv_v_alu_group_sequencer.sv
// Splits one register-group vector ALU instruction (LMUL 1..8) into one
// micro-op per register, with alignment checking and reduction chaining.

module riscv_v_alu_group_sequencer #(
  parameter int REG_IDX_W   = 5,
  parameter int CTRL_W      = 32,
  parameter int LMUL_LOG2_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  AluGroupReqIf.slave  reqIf,
  AluGroupUopIf.master uopIf,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic {IDLE, ISSUE} SeqState;

  SeqState                r_state;
  logic [2:0]             r_idx;
  logic [LMUL_LOG2_W-1:0] r_lmul;
  logic [REG_IDX_W-1:0]   r_vs1;
  logic [REG_IDX_W-1:0]   r_vs2;
  logic [REG_IDX_W-1:0]   r_vd;
  logic                   r_isReduct;
  logic                   r_isMaskDst;
  logic                   r_done;
  logic                   r_err;

  logic                   r_uopValid;
  logic [CTRL_W-1:0]      r_uopCtrl;
  logic [REG_IDX_W-1:0]   r_uopVs1;
  logic [REG_IDX_W-1:0]   r_uopVs2;
  logic [REG_IDX_W-1:0]   r_uopVd;
  logic                   r_uopFirst;
  logic                   r_uopLast;
  logic                   r_uopUseAcc;

  logic                   w_accept;
  logic [REG_IDX_W-1:0]   w_reqMask;
  logic                   w_misaligned;
  logic [3:0]             w_groupSize;
  logic [2:0]             w_lastIdx;
  logic                   w_uopFire;
  logic [2:0]             w_nextIdx;
  logic [REG_IDX_W-1:0]   w_nextOff;

  assign reqIf.req_ready = (r_state == IDLE) && !rst;
  assign w_accept        = reqIf.req_valid && reqIf.req_ready;

  // Low lmul_log2 bits of every checked base must be zero for an aligned group.
  assign w_reqMask    = ~({REG_IDX_W{1'b1}} << reqIf.req_lmul_log2);
  assign w_misaligned = (|(reqIf.req_vs2 & w_reqMask))
                     || (!reqIf.req_is_reduct && |(reqIf.req_vs1 & w_reqMask))
                     || (!reqIf.req_is_reduct && !reqIf.req_is_mask_dst
                         && |(reqIf.req_vd & w_reqMask));

  assign w_groupSize = 4'd1 << r_lmul;
  assign w_lastIdx   = 3'(w_groupSize - 4'd1);
  assign w_uopFire   = r_uopValid && uopIf.uop_ready;
  assign w_nextIdx   = r_idx + 3'd1;
  assign w_nextOff   = {{(REG_IDX_W-3){1'b0}}, w_nextIdx};

  // Micro-op fields are precomputed one cycle ahead so every output is a flop
  // and holds naturally under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_lmul      <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vd        <= '0;
      r_isReduct  <= 1'b0;
      r_isMaskDst <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_uopValid  <= 1'b0;
      r_uopCtrl   <= '0;
      r_uopVs1    <= '0;
      r_uopVs2    <= '0;
      r_uopVd     <= '0;
      r_uopFirst  <= 1'b0;
      r_uopLast   <= 1'b0;
      r_uopUseAcc <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lmul      <= reqIf.req_lmul_log2;
            r_vs1       <= reqIf.req_vs1;
            r_vs2       <= reqIf.req_vs2;
            r_vd        <= reqIf.req_vd;
            r_isReduct  <= reqIf.req_is_reduct;
            r_isMaskDst <= reqIf.req_is_mask_dst;
            if (w_misaligned) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= ISSUE;
              r_idx       <= '0;
              r_uopValid  <= 1'b1;
              r_uopCtrl   <= reqIf.req_ctrl;
              r_uopVs1    <= reqIf.req_vs1;
              r_uopVs2    <= reqIf.req_vs2;
              r_uopVd     <= reqIf.req_vd;
              r_uopFirst  <= 1'b1;
              r_uopLast   <= (reqIf.req_lmul_log2 == '0);
              r_uopUseAcc <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (w_uopFire) begin
            if (r_idx == w_lastIdx) begin
              r_state     <= IDLE;
              r_idx       <= '0;
              r_done      <= 1'b1;
              r_uopValid  <= 1'b0;
              r_uopCtrl   <= '0;
              r_uopVs1    <= '0;
              r_uopVs2    <= '0;
              r_uopVd     <= '0;
              r_uopFirst  <= 1'b0;
              r_uopLast   <= 1'b0;
              r_uopUseAcc <= 1'b0;
            end else begin
              // Reductions keep the scalar vs1 and single vd; later steps chain the accumulator.
              r_idx       <= w_nextIdx;
              r_uopVs2    <= r_vs2 + w_nextOff;
              r_uopVs1    <= r_isReduct ? r_vs1 : r_vs1 + w_nextOff;
              r_uopVd     <= (r_isReduct || r_isMaskDst) ? r_vd : r_vd + w_nextOff;
              r_uopFirst  <= 1'b0;
              r_uopLast   <= (w_nextIdx == w_lastIdx);
              r_uopUseAcc <= r_isReduct;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uopIf.uop_valid   = r_uopValid;
  assign uopIf.uop_ctrl    = r_uopCtrl;
  assign uopIf.uop_vs1     = r_uopVs1;
  assign uopIf.uop_vs2     = r_uopVs2;
  assign uopIf.uop_vd      = r_uopVd;
  assign uopIf.uop_idx     = r_idx;
  assign uopIf.uop_first   = r_uopFirst;
  assign uopIf.uop_last    = r_uopLast;
  assign uopIf.uop_use_acc = r_uopUseAcc;

  assign busy = (r_state == ISSUE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_riscv_v_alu_group_sequencer.sv
// Directed bench for the vector ALU group sequencer; every expected value is
// derived here from the request bases and the micro-op position.

module tb_riscv_v_alu_group_sequencer;

  logic clk;
  logic rst;
  logic busy;
  logic done;
  logic err;

  int testsRun;
  int testsFailed;

  AluGroupReqIf #(.REG_IDX_W(5), .CTRL_W(32), .LMUL_LOG2_W(2)) reqIf ();
  AluGroupUopIf #(.REG_IDX_W(5), .CTRL_W(32)) uopIf ();

  riscv_v_alu_group_sequencer #(
    .REG_IDX_W(5),
    .CTRL_W(32),
    .LMUL_LOG2_W(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .reqIf(reqIf),
    .uopIf(uopIf),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  // 10 ns clock; all driving and sampling happens on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request for exactly one rising edge; caller must be at a falling edge.
  task automatic applyStimulus(input logic [1:0] lmul, input logic [4:0] vs1,
                               input logic [4:0] vs2, input logic [4:0] vd,
                               input logic red, input logic maskDst,
                               input logic [31:0] ctrl);
    reqIf.req_valid       = 1'b1;
    reqIf.req_lmul_log2   = lmul;
    reqIf.req_vs1         = vs1;
    reqIf.req_vs2         = vs2;
    reqIf.req_vd          = vd;
    reqIf.req_is_reduct   = red;
    reqIf.req_is_mask_dst = maskDst;
    reqIf.req_ctrl        = ctrl;
    checkOutput("req_ready_at_accept", 32'(reqIf.req_ready), 32'd1);
    @(negedge clk);
    reqIf.req_valid       = 1'b0;
    reqIf.req_ctrl        = 32'hDEAD_BEEF;
    reqIf.req_vs1         = 5'd31;
    reqIf.req_vs2         = 5'd31;
    reqIf.req_vd          = 5'd31;
  endtask

  task automatic checkUop(input int k, input int n, input logic [4:0] vs1,
                          input logic [4:0] vs2, input logic [4:0] vd,
                          input logic red, input logic maskDst,
                          input logic [31:0] ctrl);
    logic [4:0] expVs1;
    logic [4:0] expVd;
    expVs1 = red ? vs1 : vs1 + 5'(k);
    expVd  = (red || maskDst) ? vd : vd + 5'(k);
    checkOutput("uop_valid",   32'(uopIf.uop_valid), 32'd1);
    checkOutput("uop_ctrl",    uopIf.uop_ctrl, ctrl);
    checkOutput("uop_vs1",     32'(uopIf.uop_vs1), 32'(expVs1));
    checkOutput("uop_vs2",     32'(uopIf.uop_vs2), 32'(vs2 + 5'(k)));
    checkOutput("uop_vd",      32'(uopIf.uop_vd), 32'(expVd));
    checkOutput("uop_idx",     32'(uopIf.uop_idx), 32'(k));
    checkOutput("uop_first",   32'(uopIf.uop_first), 32'(k == 0));
    checkOutput("uop_last",    32'(uopIf.uop_last), 32'(k == n - 1));
    checkOutput("uop_use_acc", 32'(uopIf.uop_use_acc), 32'(red && k != 0));
    checkOutput("busy_issue",  32'(busy), 32'd1);
    checkOutput("done_issue",  32'(done), 32'd0);
    checkOutput("err_issue",   32'(err), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(uopIf.uop_valid), 32'd0);
    checkOutput({tag, "_ctrl"},  uopIf.uop_ctrl, 32'd0);
    checkOutput({tag, "_vs1"},   32'(uopIf.uop_vs1), 32'd0);
    checkOutput({tag, "_vs2"},   32'(uopIf.uop_vs2), 32'd0);
    checkOutput({tag, "_vd"},    32'(uopIf.uop_vd), 32'd0);
    checkOutput({tag, "_idx"},   32'(uopIf.uop_idx), 32'd0);
    checkOutput({tag, "_flags"}, {29'd0, uopIf.uop_first, uopIf.uop_last, uopIf.uop_use_acc}, 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // Issues a whole aligned group with uop_ready high and ends in the done cycle.
  task automatic runGroup(input logic [1:0] lmul, input logic [4:0] vs1,
                          input logic [4:0] vs2, input logic [4:0] vd,
                          input logic red, input logic maskDst,
                          input logic [31:0] ctrl);
    int n;
    n = 1 << lmul;
    uopIf.uop_ready = 1'b1;
    applyStimulus(lmul, vs1, vs2, vd, red, maskDst, ctrl);
    for (int k = 0; k < n; k++) begin
      checkUop(k, n, vs1, vs2, vd, red, maskDst, ctrl);
      @(negedge clk);
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("err_at_done", 32'(err), 32'd0);
    checkOutput("ready_at_done", 32'(reqIf.req_ready), 32'd1);
    checkIdleOutputs("after_group");
  endtask

  initial begin
    testsRun              = 0;
    testsFailed           = 0;
    rst                   = 1'b1;
    reqIf.req_valid       = 1'b0;
    reqIf.req_ctrl        = '0;
    reqIf.req_lmul_log2   = '0;
    reqIf.req_vs1         = '0;
    reqIf.req_vs2         = '0;
    reqIf.req_vd          = '0;
    reqIf.req_is_reduct   = 1'b0;
    reqIf.req_is_mask_dst = 1'b0;
    uopIf.uop_ready       = 1'b1;

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_ready", 32'(reqIf.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(reqIf.req_ready), 32'd1);

    // LMUL=1 single micro-op, done two cycles after accept.
    runGroup(2'd0, 5'd3, 5'd5, 5'd7, 1'b0, 1'b0, 32'h1234_0001);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);

    // LMUL=8 followed immediately by a back-to-back request in the done cycle.
    runGroup(2'd3, 5'd8, 5'd16, 5'd24, 1'b0, 1'b0, 32'hA5A5_0008);
    runGroup(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0000_00B2);
    @(negedge clk);

    // Reduction: scalar vs1 and single vd stay fixed, accumulator chains from idx 1.
    runGroup(2'd2, 5'd1, 5'd4, 5'd2, 1'b1, 1'b0, 32'h0BAD_0004);
    @(negedge clk);

    // Backpressure on idx 0 for three cycles.
    uopIf.uop_ready = 1'b0;
    applyStimulus(2'd1, 5'd2, 5'd4, 5'd6, 1'b0, 1'b0, 32'h5555_0002);
    checkUop(0, 2, 5'd2, 5'd4, 5'd6, 1'b0, 1'b0, 32'h5555_0002);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkUop(0, 2, 5'd2, 5'd4, 5'd6, 1'b0, 1'b0, 32'h5555_0002);
    end
    uopIf.uop_ready = 1'b1;
    @(negedge clk);
    checkUop(1, 2, 5'd2, 5'd4, 5'd6, 1'b0, 1'b0, 32'h5555_0002);
    @(negedge clk);
    checkOutput("bp_done", 32'(done), 32'd1);
    @(negedge clk);

    // Misaligned vs2=6 for LMUL=4: handshake completes, single err pulse.
    applyStimulus(2'd2, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 32'hEEEE_0004);
    checkOutput("misalign_err", 32'(err), 32'd1);
    checkOutput("misalign_done", 32'(done), 32'd0);
    checkIdleOutputs("misalign");
    @(negedge clk);
    checkOutput("misalign_err_drop", 32'(err), 32'd0);
    checkIdleOutputs("misalign_next");

    // Mask destination vd=2 is exempt from the alignment check.
    applyStimulus(2'd2, 5'd0, 5'd4, 5'd2, 1'b0, 1'b1, 32'h3333_0004);
    checkOutput("maskdst_no_err", 32'(err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkUop(k, 4, 5'd0, 5'd4, 5'd2, 1'b0, 1'b1, 32'h3333_0004);
      @(negedge clk);
    end
    checkOutput("maskdst_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset at idx 2 of an LMUL=8 group aborts without done.
    applyStimulus(2'd3, 5'd0, 5'd8, 5'd16, 1'b0, 1'b0, 32'h7777_0008);
    for (int k = 0; k < 3; k++) begin
      checkUop(k, 8, 5'd0, 5'd8, 5'd16, 1'b0, 1'b0, 32'h7777_0008);
      if (k < 2) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midrst");
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_ready", 32'(reqIf.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_midrst", 32'(reqIf.req_ready), 32'd1);
    @(negedge clk);
    checkOutput("no_done_after_rst", 32'(done), 32'd0);
    checkIdleOutputs("post_rst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/riscv_v_alu_group_sequencer.md
Name: riscv_v_alu_group_sequencer

Overview:
- Breaks one vector arithmetic instruction that spans a register group (LMUL = 1, 2, 4 or 8) into per-register micro-ops for the vector arithmetic ALU.
- Issues one micro-op per accepted handshake, with register indices, position flags and reduction-accumulate chaining.
- Sits between decode/issue and the ALU operand-read stage. The ALU control bundle passes through opaquely.
- Checks register-group alignment and reports misaligned requests instead of issuing them.

Parameters:
- REG_IDX_W, 5, width of a vector register index (32 architectural registers).
- CTRL_W, 32, width of the opaque ALU control bundle (is_add/is_sub/is_mul/.../osize vectors) carried per micro-op.
- LMUL_LOG2_W, 2, width of the LMUL encoding; value n means group size 2^n.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  instruction request valid.
- req_ready  output  1  sequencer can accept a request.
- req_ctrl  input  CTRL_W  ALU control bundle.
- req_lmul_log2  input  LMUL_LOG2_W  group size 2^n (0..3).
- req_vs1  input  REG_IDX_W  base of source A (scalar register for reductions).
- req_vs2  input  REG_IDX_W  base of source B group.
- req_vd  input  REG_IDX_W  base of destination group.
- req_is_reduct  input  1  reduction instruction.
- req_is_mask_dst  input  1  compare op writing a single mask register.
- uop_valid  output  1  micro-op valid.
- uop_ready  input  1  ALU stage accepts micro-op.
- uop_ctrl  output  CTRL_W  latched req_ctrl.
- uop_vs1, uop_vs2, uop_vd  output  REG_IDX_W each  register indices for this micro-op.
- uop_idx  output  3  position within the group.
- uop_first  output  1  first micro-op of the group.
- uop_last  output  1  last micro-op of the group.
- uop_use_acc  output  1  srca comes from the running reduction accumulator, not vs1.
- busy  output  1  sequencer not in IDLE.
- done  output  1  one-cycle pulse after the last micro-op handshake.
- err  output  1  one-cycle pulse: misaligned request rejected.

Behaviour:
- Reset:
  - state = IDLE, idx = 0.
  - All outputs = 0, including uop_* fields.
  - req_ready is forced to 0 while rst = 1.
  - Reset in any state aborts the group with no done and no err.
- States: IDLE and ISSUE.
- req_ready = (state == IDLE) && !rst. Accept = req_valid && req_ready; on accept, all req_* fields are latched.
- Group size N = 1 << lmul_log2.
- Alignment check at accept (a field is misaligned when it is non-zero modulo N):
  - vs2 is always checked.
  - vs1 is checked unless is_reduct.
  - vd is checked unless is_reduct or is_mask_dst.
- Misaligned request: the handshake completes, state stays IDLE, no micro-ops issue, err = 1 in the next cycle only.
- Aligned request: IDLE -> ISSUE; idx = 0; uop_valid = 1 from the next cycle.
- In ISSUE:
  - uop_valid = 1.
  - uop_vs2 = vs2 + idx.
  - uop_vs1 = is_reduct ? vs1 : vs1 + idx.
  - uop_vd = (is_reduct || is_mask_dst) ? vd : vd + idx.
  - uop_first = (idx == 0); uop_last = (idx == N-1).
  - uop_use_acc = is_reduct && idx != 0.
  - uop_ctrl = latched ctrl.
  - Index sums cannot overflow because groups are aligned.
- Backpressure: while uop_valid && !uop_ready, every uop_* output holds stable and idx does not advance.
- On a handshake (uop_valid && uop_ready):
  - idx != N-1: idx increments.
  - idx == N-1: go to IDLE, uop_valid = 0 and uop_* = 0 next cycle, done = 1 next cycle.
- req_ready is 1 in the done cycle, so a new request can be accepted back-to-back.
- Latency with uop_ready held at 1: accept at cycle T, micro-ops at T+1..T+N, done at T+N+1. Maximum throughput is one micro-op per cycle.
- busy = (state == ISSUE).
- done and err are never asserted in the same cycle.
- req_* inputs are ignored while not in IDLE.

Test Plan:
- LMUL=1, vs1=3, vs2=5, vd=7, uop_ready=1: accept at T -> one micro-op at T+1 (3,5,7) with first=last=1, idx=0; done at T+2.
- LMUL=8, vs1=8, vs2=16, vd=24, uop_ready=1: micro-ops at T+1..T+8 with vs2=16..23, vd=24..31, vs1=8..15; last only on idx=7; done at T+9; a second request accepted at T+9.
- Reduction, LMUL=4, vs1=1, vs2=4, vd=2: vs1 and vd stay 1 and 2; vs2 = 4..7; use_acc = 0,1,1,1; no err.
- Backpressure, LMUL=2: uop_ready=0 for 3 cycles on idx=0 -> all uop_* fields stable, idx stays 0, busy=1; then two handshakes -> done.
- Misaligned, LMUL=4, vs2=6 -> req accepted, err=1 for exactly one cycle, uop_valid never 1, busy stays 0; vd=2 with is_mask_dst=1 and vs2=4 -> no err.
- rst=1 asserted mid-group at idx=2 of LMUL=8 -> next cycle all outputs 0, state IDLE, no done; req_ready=1 after rst deasserts.
